pc_fetch_unit: RTL and testbench

Parametrised program-counter and fetch-request unit for the 5-stage MIPS pipeline. Sits between decode and the instruction SRAM port. It issues word fetches over a valid/ack handshake and resolves eight branch conditions plus J/JR. It honours the branch delay slot, buffers redirects until the in-flight fetch is accepted, and gives exception entry and ERET priority over branches.

---
 rtl/pc_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch request generator for the 5-stage MIPS pipeline.
// Resolves branches/jumps with a delay slot, holds redirects until the in-flight fetch is accepted.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
   parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
   parameter int          BTYPE_W      = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               stall,
   input  logic               br_valid,
   input  logic               is_b,
   input  logic               is_j,
   input  logic               is_jr,
   input  logic               is_link,
   input  logic [BTYPE_W-1:0] b_type,
   input  logic [15:0]        b_offset,
   input  logic [25:0]        j_index,
   input  logic [31:0]        br_pc,
   input  logic [31:0]        rs_value,
   input  logic [31:0]        rt_value,
   input  logic               exc_valid,
   input  logic               eret_valid,
   input  logic [31:0]        epc,
   output logic               inst_req,
   output logic [31:0]        inst_addr,
   input  logic               inst_ack,
   output logic               inst_discard,
   output logic               br_taken,
   output logic [31:0]        link_addr,
   output logic               addr_err,
   output logic               busy
);

   typedef enum logic {RUN, PEND} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] pend_target_reg, pend_target_next;
   logic        pend_discard_reg, pend_discard_next;
   logic        req_reg, req_next;
   logic        addr_err_reg, addr_err_next;

   logic signed [31:0] rs_signed;
   logic               cond_true;
   logic [31:0]        br_pc_plus4, b_target, j_target;
   logic               accept, take_br;
   logic               ev_valid, ev_discard, ev_misaligned;
   logic [31:0]        ev_target;
   logic               unused_link;

   // link_addr is produced for every control-flow op; is_link only tells decode to write it
   assign unused_link = is_link;

   assign rs_signed   = $signed(rs_value);
   assign br_pc_plus4 = br_pc + 32'd4;
   assign b_target    = br_pc_plus4 + {{14{b_offset[15]}}, b_offset, 2'b00};
   assign j_target    = {br_pc_plus4[31:28], j_index, 2'b00};

   always_comb begin
      cond_true = 1'b0;
      case (b_type)
         BTYPE_W'(0): cond_true = (rs_value == rt_value);
         BTYPE_W'(1): cond_true = (rs_value != rt_value);
         BTYPE_W'(2): cond_true = (rs_signed >= 0);
         BTYPE_W'(3): cond_true = (rs_signed > 0);
         BTYPE_W'(4): cond_true = (rs_signed <= 0);
         BTYPE_W'(5): cond_true = (rs_signed < 0);
         BTYPE_W'(6): cond_true = (rs_signed >= 0);
         BTYPE_W'(7): cond_true = (rs_signed < 0);
         default:     cond_true = 1'b0;
      endcase
   end

   assign br_taken  = br_valid & (is_j | is_jr | (is_b & cond_true));
   assign link_addr = br_pc + 32'd8;

   assign accept  = req_reg & inst_ack;
   assign take_br = br_taken & (state_reg == RUN);

   // Redirect source, highest priority first: exception, ERET, taken branch
   always_comb begin
      ev_valid      = 1'b1;
      ev_target     = EXC_VECTOR;
      ev_discard    = 1'b1;
      ev_misaligned = 1'b0;
      if (exc_valid) begin
         ev_target = EXC_VECTOR;
      end else if (eret_valid) begin
         ev_target     = epc;
         ev_misaligned = |epc[1:0];
      end else if (take_br) begin
         ev_target     = is_jr ? rs_value : (is_j ? j_target : b_target);
         ev_discard    = (pc_reg != br_pc_plus4);
         ev_misaligned = is_jr & (|rs_value[1:0]);
      end else begin
         ev_valid = 1'b0;
      end
   end

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      pend_target_next  = pend_target_reg;
      pend_discard_next = pend_discard_reg;
      addr_err_next     = 1'b0;
      inst_discard      = 1'b0;
      if (ev_valid) begin
         addr_err_next = ev_misaligned;
         if (accept) begin
            // the word accepted now is the one in flight at event time
            inst_discard = ev_discard;
            pc_next      = ev_target;
            state_next   = RUN;
         end else begin
            pend_target_next  = ev_target;
            pend_discard_next = ev_discard;
            state_next        = PEND;
         end
      end else if (accept) begin
         if (state_reg == PEND) begin
            inst_discard = pend_discard_reg;
            pc_next      = pend_target_reg;
            state_next   = RUN;
         end else begin
            pc_next = pc_reg + 32'd4;
         end
      end
      req_next = (req_reg & ~inst_ack) ? 1'b1 : ~stall;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg        <= RUN;
         pc_reg           <= RESET_VECTOR;
         pend_target_reg  <= RESET_VECTOR;
         pend_discard_reg <= 1'b0;
         req_reg          <= 1'b0;
         addr_err_reg     <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         pend_target_reg  <= pend_target_next;
         pend_discard_reg <= pend_discard_next;
         req_reg          <= req_next;
         addr_err_reg     <= addr_err_next;
      end
   end

   assign inst_req  = req_reg;
   assign inst_addr = pc_reg;
   assign addr_err  = addr_err_reg;
   assign busy      = (state_reg == PEND);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural fetch-stream model.
module tb_pc_fetch_unit;

   localparam logic [31:0] RV = 32'hbfc00000;
   localparam logic [31:0] EV = 32'hbfc00380;

   logic        clk = 1'b0, resetn = 1'b1, stall = 1'b0;
   logic        br_valid = 1'b0, is_b = 1'b0, is_j = 1'b0, is_jr = 1'b0, is_link = 1'b0;
   logic [3:0]  b_type = '0;
   logic [15:0] b_offset = '0;
   logic [25:0] j_index = '0;
   logic [31:0] br_pc = '0, rs_value = '0, rt_value = '0, epc = '0;
   logic        exc_valid = 1'b0, eret_valid = 1'b0, inst_ack = 1'b0;
   logic        inst_req, inst_discard, br_taken, addr_err, busy;
   logic [31:0] inst_addr, link_addr;

   int checks = 0, failures = 0;

   // model state: address of the current request and any redirect still waiting
   logic [31:0] m_pc, m_ptarget;
   bit          m_req, m_pend, m_pdisc, m_aerr;
   bit          last_disc, last_taken;

   pc_fetch_unit dut (
      .clk(clk), .resetn(resetn), .stall(stall), .br_valid(br_valid),
      .is_b(is_b), .is_j(is_j), .is_jr(is_jr), .is_link(is_link),
      .b_type(b_type), .b_offset(b_offset), .j_index(j_index), .br_pc(br_pc),
      .rs_value(rs_value), .rt_value(rt_value), .exc_valid(exc_valid),
      .eret_valid(eret_valid), .epc(epc), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_ack(inst_ack), .inst_discard(inst_discard), .br_taken(br_taken),
      .link_addr(link_addr), .addr_err(addr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit m_cond();
      int rs;
      rs = rs_value;
      case (b_type)
         4'd0:       return rs_value == rt_value;
         4'd1:       return rs_value != rt_value;
         4'd2, 4'd6: return rs >= 0;
         4'd3:       return rs > 0;
         4'd4:       return rs <= 0;
         4'd5, 4'd7: return rs < 0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_target();
      logic [31:0] p4;
      int off;
      p4  = br_pc + 32'd4;
      off = int'($signed(b_offset));
      if (is_jr) return rs_value;
      if (is_j)  return {p4[31:28], j_index, 2'b00};
      return p4 + 32'(off * 4);
   endfunction

   task automatic model_reset();
      m_pc = RV; m_ptarget = '0; m_req = 0; m_pend = 0; m_pdisc = 0; m_aerr = 0;
   endtask

   task automatic clear_inputs();
      br_valid = 0; is_b = 0; is_j = 0; is_jr = 0; is_link = 0;
      exc_valid = 0; eret_valid = 0;
   endtask

   // one clock: compare everything against the model, then advance the model
   task automatic cycle();
      logic [31:0] tgt;
      bit ev, disc, mis, acc, exp_t, exp_d;
      #2;
      exp_t = br_valid && (is_j || is_jr || (is_b && m_cond()));
      check("br_taken", br_taken, exp_t);
      check("link_addr", link_addr, br_pc + 32'd8);
      check("inst_req", inst_req, m_req);
      if (m_req) check("inst_addr", inst_addr, m_pc);
      check("busy", busy, m_pend);
      check("addr_err", addr_err, m_aerr);
      acc = m_req && inst_ack;
      ev = 1; disc = 1; mis = 0; tgt = EV;
      if (exc_valid) begin
         tgt = EV;
      end else if (eret_valid) begin
         tgt = epc;
         mis = (epc[1:0] != 2'b00);
      end else if (exp_t && !m_pend) begin
         tgt  = m_target();
         disc = (m_pc != br_pc + 32'd4);
         mis  = is_jr && (rs_value[1:0] != 2'b00);
      end else begin
         ev = 0;
      end
      exp_d = acc && (ev ? disc : (m_pend && m_pdisc));
      check("inst_discard", inst_discard, exp_d);
      last_disc  = inst_discard;
      last_taken = br_taken;
      if (acc) $display("accept addr=%h discard=%b", inst_addr, inst_discard);
      @(posedge clk);
      m_aerr = ev && mis;
      if (ev && acc) begin
         m_pc = tgt; m_pend = 0;
      end else if (ev) begin
         m_pend = 1; m_ptarget = tgt; m_pdisc = disc;
      end else if (acc && m_pend) begin
         m_pc = m_ptarget; m_pend = 0;
      end else if (acc) begin
         m_pc = m_pc + 32'd4;
      end
      m_req = (m_req && !inst_ack) ? 1'b1 : !stall;
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", inst_req, 0);
      check("rst_busy", busy, 0);
      check("rst_aerr", addr_err, 0);
      check("rst_disc", inst_discard, 0);
      @(negedge clk) resetn = 1;
      @(posedge clk);
      m_req = !stall;
      #1;
   endtask

   task automatic run_to(logic [31:0] a);
      int n;
      n = 0;
      while (m_pc != a && n < 64) begin
         cycle();
         n++;
      end
      check("run_to", inst_addr, a);
   endtask

   task automatic set_b(logic [3:0] ty, logic [31:0] bpc, logic [31:0] rs, logic [31:0] rt,
                        logic [15:0] off);
      clear_inputs();
      br_valid = 1; is_b = 1; b_type = ty; br_pc = bpc;
      rs_value = rs; rt_value = rt; b_offset = off;
   endtask

   logic [31:0] rs_pick [6] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h5};
   logic [31:0] bnd_rs [3] = '{32'h0, 32'h1, 32'h80000000};
   logic [3:0]  bnd_ty [3] = '{4'd3, 4'd4, 4'd5};
   bit          bnd_exp [3][3] = '{'{0, 1, 0}, '{1, 0, 1}, '{0, 0, 1}};

   initial begin
      logic [31:0] saved;
      int r;
      inst_ack = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         check("rst_seq", inst_addr, RV + 32'(4 * i));
         cycle();
      end

      // taken BEQ with the delay slot in flight
      do_reset();
      run_to(32'hbfc00014);
      set_b(4'd0, 32'hbfc00010, 32'd5, 32'd5, 16'h0003);
      cycle();
      clear_inputs();
      check("beq_keep_disc", last_disc, 0);
      check("beq_keep_tgt", inst_addr, 32'hbfc00020);
      cycle();

      // taken BEQ with a wrong-path word in flight
      do_reset();
      run_to(32'hbfc00018);
      set_b(4'd0, 32'hbfc00010, 32'd5, 32'd5, 16'h0003);
      cycle();
      clear_inputs();
      check("beq_drop_disc", last_disc, 1);
      check("beq_drop_tgt", inst_addr, 32'hbfc00020);

      // not taken
      do_reset();
      run_to(32'hbfc00018);
      set_b(4'd0, 32'hbfc00010, 32'd6, 32'd5, 16'h0003);
      cycle();
      clear_inputs();
      check("beq_nt_disc", last_disc, 0);
      check("beq_nt_seq", inst_addr, 32'hbfc0001c);

      // signed boundaries
      for (int t = 0; t < 3; t++) begin
         for (int v = 0; v < 3; v++) begin
            set_b(bnd_ty[t], m_pc - 32'd4, bnd_rs[v], 32'd0, 16'h0001);
            cycle();
            check("sign_taken", last_taken, bnd_exp[t][v]);
         end
      end
      set_b(4'd6, m_pc - 32'd4, 32'd0, 32'd0, 16'h0002);
      is_link = 1;
      #1 check("bgezal_link", link_addr, m_pc + 32'd4);
      cycle();
      clear_inputs();

      // J and exception together while the fetch is held off
      inst_ack = 0;
      saved = inst_addr;
      br_valid = 1; is_j = 1; j_index = 26'h0000100; br_pc = m_pc - 32'd4;
      exc_valid = 1;
      cycle();
      clear_inputs();
      for (int i = 0; i < 2; i++) begin
         check("exc_hold", inst_addr, saved);
         check("exc_busy", busy, 1);
         cycle();
      end
      inst_ack = 1;
      cycle();
      check("exc_disc", last_disc, 1);
      check("exc_tgt", inst_addr, EV);

      // misaligned ERET target
      eret_valid = 1; epc = 32'h80000002;
      cycle();
      clear_inputs();
      check("eret_aerr", addr_err, 1);
      check("eret_tgt", inst_addr, 32'h80000002);
      cycle();
      check("eret_aerr_off", addr_err, 0);

      // reset while a redirect is pending
      inst_ack = 0;
      exc_valid = 1;
      cycle();
      clear_inputs();
      check("pend_busy", busy, 1);
      inst_ack = 1;
      do_reset();
      check("rst_pend_addr", inst_addr, RV);
      cycle();

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         clear_inputs();
         stall    = ($urandom % 4) == 0;
         inst_ack = ($urandom % 3) != 0;
         r = $urandom % 100;
         exc_valid  = r < 4;
         eret_valid = (r >= 3) && (r < 8);
         epc        = $urandom;
         if (r >= 6 && r < 40 && (!m_pend || ($urandom % 8) == 0)) begin
            br_valid = 1;
            case ($urandom % 4)
               0, 1:    is_b = 1;
               2:       is_j = 1;
               default: is_jr = 1;
            endcase
            is_link  = $urandom % 2;
            b_type   = 4'($urandom % 16);
            b_offset = 16'($urandom);
            j_index  = 26'($urandom);
            br_pc    = m_pc - ((($urandom % 2) == 0) ? 32'd4 : 32'd8);
            rs_value = (($urandom % 3) == 0) ? $urandom : rs_pick[$urandom % 6];
            rt_value = (($urandom % 2) == 0) ? rs_value : rs_pick[$urandom % 6];
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
